fetch_controller: RTL and testbench

Sequences the Y86-64 fetch stage. Owns the F pipeline register (predicted PC) and selects the fetch PC from the prediction, a mispredicted-branch recovery, or a return address. Classifies the fetched instruction's status, and freezes or bubbles fetch around ret, halt and error conditions. It sits between the instruction memory/split/align/PC-increment logic and the D pipeline register.

---
 rtl/fetch_controller.sv | 141 ++++++++++++++
 tb/tb_fetch_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller
//   Y86-64 fetch-stage sequencer. Owns the F pipeline register (predicted PC),
//   picks the fetch PC (branch recovery, return address or prediction),
//   classifies the fetched instruction's status and bubbles fetch while a ret
//   is in flight, after a halt/error, and once the machine has stopped.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   f_icode/valC/valP   decoded fields of the instruction at f_pc
//   imem_error          fetch address out of range
//   instr_valid         icode is a legal instruction
//   F_stall             hazard-unit stall of the F register
//   M_icode/M_Cnd/M_valA  jXX resolution in M (valA = fall-through PC)
//   W_icode/W_valM      ret in W and the return address it read
//   W_halt              architectural stop has reached W
//   f_pc                selected fetch address
//   F_predPC            registered predicted PC
//   f_stat              0 AOK, 1 HLT, 2 ADR, 3 INS
//   f_bubble            D loads a nop instead of the fetched instruction
//   fetch_count         saturating count of instructions accepted into D
//   ctl_state           0 RUN, 1 RET_WAIT, 2 STOPPED, 3 DONE
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       f_icode,
    input  logic [63:0]      f_valC,
    input  logic [63:0]      f_valP,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             F_stall,
    input  logic [3:0]       M_icode,
    input  logic             M_Cnd,
    input  logic [63:0]      M_valA,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valM,
    input  logic             W_halt,
    output logic [63:0]      f_pc,
    output logic [63:0]      F_predPC,
    output logic [1:0]       f_stat,
    output logic             f_bubble,
    output logic [CNT_W-1:0] fetch_count,
    output logic [1:0]       ctl_state
);

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ADR = 2'd2;
    localparam logic [1:0] S_INS = 2'd3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        STOPPED  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [63:0]      pred_q, pred_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        mispredict, ret_done, redirect;
    logic        resume, accept;
    logic [63:0] next_pred;

    assign mispredict = (M_icode == I_JXX) && !M_Cnd;
    assign ret_done   = (W_icode == I_RET);
    assign redirect   = mispredict || ret_done;

    // Fetch PC: branch recovery beats return address beats prediction.
    always_comb begin
        if (mispredict)    f_pc = M_valA;
        else if (ret_done) f_pc = W_valM;
        else               f_pc = pred_q;
    end

    always_comb begin
        if (imem_error)             f_stat = S_ADR;
        else if (!instr_valid)      f_stat = S_INS;
        else if (f_icode == I_HALT) f_stat = S_HLT;
        else                        f_stat = S_AOK;
    end

    assign next_pred = (f_icode == I_JXX || f_icode == I_CALL) ? f_valC : f_valP;

    // A frozen state restarts only on the redirect that resolves it: any
    // redirect ends a ret wait, only a mispredict squashes a speculative stop.
    assign resume = ((state_q == RET_WAIT) && redirect) ||
                    ((state_q == STOPPED)  && mispredict);

    // Redirects override F_stall. W_halt blocks all updates that cycle since
    // the machine is stopping anyway.
    assign accept = !W_halt &&
                    (((state_q == RUN) && (!F_stall || redirect)) || resume);

    // In RUN, a stall is handled by D itself, so no bubble is needed.
    assign f_bubble = !((state_q == RUN) || resume);

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        cnt_d   = cnt_q;
        if (W_halt) begin
            state_d = DONE;
        end else if (accept) begin
            pred_d = next_pred;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            if (state_q == RUN) begin
                if (f_stat != S_AOK)       state_d = STOPPED;
                else if (f_icode == I_RET) state_d = RET_WAIT;
                else                       state_d = RUN;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pred_q  <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            cnt_q   <= cnt_d;
        end
    end

    assign F_predPC    = pred_q;
    assign fetch_count = cnt_q;
    assign ctl_state   = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    localparam logic [63:0] RPC = 64'h10;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0]  f_icode = 4'h1;
    logic [63:0] f_valC = '0, f_valP = '0;
    logic imem_error = 1'b0, instr_valid = 1'b1, F_stall = 1'b0;
    logic [3:0]  M_icode = 4'h1;
    logic        M_Cnd = 1'b0;
    logic [63:0] M_valA = '0;
    logic [3:0]  W_icode = 4'h1;
    logic [63:0] W_valM = '0;
    logic        W_halt = 1'b0;
    logic [63:0] f_pc, F_predPC;
    logic [1:0]  f_stat, ctl_state;
    logic        f_bubble;
    logic [CW-1:0] fetch_count;

    fetch_controller #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .f_icode(f_icode), .f_valC(f_valC),
        .f_valP(f_valP), .imem_error(imem_error), .instr_valid(instr_valid),
        .F_stall(F_stall), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .W_halt(W_halt), .f_pc(f_pc),
        .F_predPC(F_predPC), .f_stat(f_stat), .f_bubble(f_bubble),
        .fetch_count(fetch_count), .ctl_state(ctl_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ic; logic [63:0] valC, valP;
        logic err, valid, stall;
        logic [3:0] Mic; logic Mc; logic [63:0] MvalA;
        logic [3:0] Wic; logic [63:0] WvalM; logic Whalt;
    } stim_t;

    typedef struct {
        logic [63:0] pc, pred; logic [1:0] stat, mode; logic bub; int cnt;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0, fails = 0;

    // Reference model: architectural mode name, predicted PC, accepted count.
    int          m_mode;   // 0 RUN, 1 waiting for ret, 2 stopped, 3 done
    logic [63:0] m_pred;
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("f_pc", f_pc, e.pc);
            chk("f_stat", 64'(f_stat), 64'(e.stat));
            chk("f_bubble", 64'(f_bubble), 64'(e.bub));
            chk("F_predPC", F_predPC, e.pred);
            chk("ctl_state", 64'(ctl_state), 64'(e.mode));
            chk("fetch_count", 64'(fetch_count), 64'(e.cnt));
        end
    end

    function automatic stim_t quiet(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
        stim_t s;
        s.ic = ic; s.valC = vc; s.valP = vp;
        s.err = 0; s.valid = 1; s.stall = 0;
        s.Mic = 4'h1; s.Mc = 0; s.MvalA = '0;
        s.Wic = 4'h1; s.WvalM = '0; s.Whalt = 0;
        return s;
    endfunction

    function automatic exp_t expect_now(input stim_t s);
        exp_t e;
        bit misp, retd, go;
        misp = (s.Mic == 4'h7) && !s.Mc;
        retd = (s.Wic == 4'h9);
        e.pc = misp ? s.MvalA : (retd ? s.WvalM : m_pred);
        e.stat = s.err ? 2'd2 : (!s.valid ? 2'd3 : (s.ic == 4'h0 ? 2'd1 : 2'd0));
        go = (m_mode == 1 && (misp || retd)) || (m_mode == 2 && misp);
        e.bub = !(m_mode == 0 || go);
        e.pred = m_pred; e.mode = 2'(m_mode); e.cnt = m_cnt;
        return e;
    endfunction

    // Apply one cycle of stimulus (called at posedge+1, returns at next posedge+1).
    task automatic drive(input stim_t s);
        exp_t e;
        bit misp, retd, take;
        f_icode = s.ic; f_valC = s.valC; f_valP = s.valP;
        imem_error = s.err; instr_valid = s.valid; F_stall = s.stall;
        M_icode = s.Mic; M_Cnd = s.Mc; M_valA = s.MvalA;
        W_icode = s.Wic; W_valM = s.WvalM; W_halt = s.Whalt;
        e = expect_now(s);
        exp_q.push_back(e);
        misp = (s.Mic == 4'h7) && !s.Mc;
        retd = (s.Wic == 4'h9);
        take = 0;
        if (s.Whalt) m_mode = 3;
        else if (m_mode == 0 && (!s.stall || misp || retd)) begin
            take = 1;
            m_mode = (e.stat != 0) ? 2 : (s.ic == 4'h9 ? 1 : 0);
        end else if ((m_mode == 1 && (misp || retd)) || (m_mode == 2 && misp)) begin
            take = 1;
            m_mode = 0;
        end
        if (take) begin
            m_pred = (s.ic == 4'h7 || s.ic == 4'h8) ? s.valC : s.valP;
            if (m_cnt < CMAX) m_cnt++;
        end
        @(posedge clk); #1;
    endtask

    // Asynchronous reset asserted mid-cycle; checked while still asserted.
    task automatic do_reset();
        stim_t s;
        #1;
        s = quiet(4'h1, '0, RPC + 1);
        f_icode = s.ic; f_valC = s.valC; f_valP = s.valP;
        imem_error = 0; instr_valid = 1; F_stall = 0;
        M_icode = 4'h1; M_Cnd = 0; W_icode = 4'h1; W_halt = 0;
        rst_n = 1'b0;
        m_mode = 0; m_pred = RPC; m_cnt = 0;
        exp_q.push_back(expect_now(s));
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        logic [3:0] tbl [0:9];
        tbl = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h7, 4'h7, 4'h8, 4'h9, 4'h9, 4'h4};
        s.ic = tbl[$urandom_range(0, 9)];
        s.valC = {$urandom, $urandom}; s.valP = {$urandom, $urandom};
        s.err = ($urandom_range(0, 31) == 0);
        s.valid = ($urandom_range(0, 15) != 0);
        s.stall = ($urandom_range(0, 3) == 0);
        s.Mic = ($urandom_range(0, 7) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
        s.Mc = 1'($urandom);
        s.MvalA = {$urandom, $urandom};
        s.Wic = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'($urandom_range(0, 8));
        s.WvalM = {$urandom, $urandom};
        s.Whalt = ($urandom_range(0, 39) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        @(posedge clk); #1;
        do_reset();
        // nop at the reset PC
        drive(quiet(4'h1, '0, 64'h11));
        // jXX predicted taken, then mispredict recovery
        drive(quiet(4'h7, 64'h40, 64'h1A));
        s = quiet(4'h1, '0, 64'h2B); s.Mic = 4'h7; s.Mc = 0; s.MvalA = 64'h2A;
        drive(s);
        // ret: three frozen cycles, then return address
        drive(quiet(4'h9, '0, 64'h2C));
        repeat (3) drive(quiet(4'h1, '0, 64'h55));
        s = quiet(4'h1, '0, 64'h81); s.Wic = 4'h9; s.WvalM = 64'h80;
        drive(s);
        // speculative halt squashed by a mispredict
        drive(quiet(4'h0, '0, 64'h82));
        drive(quiet(4'h0, '0, 64'h83));
        s = quiet(4'h1, '0, 64'h31); s.Mic = 4'h7; s.MvalA = 64'h30;
        drive(s);
        drive(quiet(4'h1, '0, 64'h32));
        // address error, then architectural stop and a frozen DONE
        s = quiet(4'h1, '0, 64'h33); s.err = 1;
        drive(s);
        s = quiet(4'h1, '0, 64'h34); s.Whalt = 1;
        drive(s);
        for (int i = 0; i < 10; i++) begin
            s = quiet(4'h8, 64'h99, 64'h98);
            if (i % 3 == 0) begin s.Mic = 4'h7; s.MvalA = 64'h70; end
            if (i % 4 == 1) begin s.Wic = 4'h9; s.WvalM = 64'h71; end
            drive(s);
        end
        // reset in the middle of a ret wait
        do_reset();
        drive(quiet(4'h9, '0, 64'h12));
        drive(quiet(4'h1, '0, 64'h13));
        do_reset();
        // stalls in RUN and saturation of the counter
        s = quiet(4'h1, '0, 64'h20); s.stall = 1;
        drive(s);
        for (int i = 0; i < 20; i++) drive(quiet(4'h1, '0, 64'(i + 64'h100)));
        // randomized traffic with periodic resets
        for (int i = 0; i < 1500; i++) begin
            if (m_mode == 3 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0))
                do_reset();
            drive(rand_stim());
        end
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
